// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive buffer.
package uart_pkg;

    // Receiver frame state machine
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    // cfg_bits encoding: number of data bits is code + 5
    localparam logic [1:0] BITS_5 = 2'b00;
    localparam logic [1:0] BITS_6 = 2'b01;
    localparam logic [1:0] BITS_7 = 2'b10;
    localparam logic [1:0] BITS_8 = 2'b11;

    // One buffered character with its error flags
    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } entry_t;

    // Index of the last data bit for a given cfg_bits code
    function automatic logic [2:0] last_bit_idx(input logic [1:0] bits);
        logic [2:0] idx;
        idx = 3'd7;
        case (bits)
            BITS_5: idx = 3'd4;
            BITS_6: idx = 3'd5;
            BITS_7: idx = 3'd6;
            BITS_8: idx = 3'd7;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with show-ahead read port. A push while full is
// accepted only if a pop happens in the same cycle; otherwise it is dropped.
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (level == '0);
    assign full_o  = (level == LW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem[rd_ptr];
    assign level_o = level;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage array; contents are meaningless until written, so no reset
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wdata_i;
    end

endmodule

// File: rtl/uart_rx_buf.sv
// UART receiver with configurable framing feeding a character FIFO.
module uart_rx_buf
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          rx_i,
    input  logic [DIV_W-1:0]              cfg_div_i,
    input  logic                          cfg_en_i,
    input  logic                          cfg_parity_en_i,
    input  logic                          cfg_parity_odd_i,
    input  logic [1:0]                    cfg_bits_i,
    output logic [7:0]                    rx_data_o,
    output logic                          rx_perr_o,
    output logic                          rx_ferr_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          busy_o,
    output logic                          overrun_o,
    output logic                          break_o,
    input  logic                          err_clr_i
);

    localparam int ENTRY_W = $bits(entry_t);

    logic             rx_p0, rx_p1;
    state_t           state, state_nxt;
    logic [DIV_W-1:0] cnt, div_q;
    logic [1:0]       bits_q;
    logic             pen_q, podd_q;
    logic [2:0]       bit_idx;
    logic [7:0]       data_q;
    logic             perr_q;
    logic             tick;
    logic             push, pop, brk_set, ovr_set;
    logic             fifo_full, fifo_empty;
    entry_t           push_entry, head;

    // Two-flop synchroniser for the asynchronous serial line, idles high
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= rx_i;
            rx_p1 <= rx_p0;
        end
    end

    assign tick = (cnt == '0);

    // FSM state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next state plus push/break strobes; disabling aborts without a push
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        brk_set   = 1'b0;
        if (!cfg_en_i) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (!rx_p1) state_nxt = ST_START;
                ST_START:  if (tick) state_nxt = rx_p1 ? ST_IDLE : ST_DATA;
                ST_DATA:   if (tick && bit_idx == last_bit_idx(bits_q))
                               state_nxt = pen_q ? ST_PARITY : ST_STOP;
                ST_PARITY: if (tick) state_nxt = ST_STOP;
                ST_STOP: begin
                    if (tick) begin
                        push = 1'b1;
                        if (!rx_p1 && data_q == 8'h00) begin
                            brk_set   = 1'b1;
                            state_nxt = ST_WAIT_HIGH;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_WAIT_HIGH: if (rx_p1) state_nxt = ST_IDLE;
                default:      state_nxt = ST_IDLE;
            endcase
        end
    end

    // Bit timer and data-bit index; half a bit from the start edge, then one bit per sample
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt     <= '0;
            bit_idx <= '0;
        end else if (state == ST_IDLE) begin
            cnt     <= cfg_div_i >> 1;
            bit_idx <= '0;
        end else if (tick) begin
            cnt <= div_q - DIV_W'(1);
            if (state == ST_DATA) bit_idx <= bit_idx + 3'd1;
        end else begin
            cnt <= cnt - DIV_W'(1);
        end
    end

    // Frame configuration is captured while idle; data bits and parity are sampled on ticks
    always_ff @(posedge clk_i) begin
        if (state == ST_IDLE) begin
            div_q  <= cfg_div_i;
            bits_q <= cfg_bits_i;
            pen_q  <= cfg_parity_en_i;
            podd_q <= cfg_parity_odd_i;
            data_q <= 8'h00;
            perr_q <= 1'b0;
        end else if (tick) begin
            if (state == ST_DATA)   data_q[bit_idx] <= rx_p1;
            if (state == ST_PARITY) perr_q <= ((^data_q) ^ rx_p1) != podd_q;
        end
    end

    assign push_entry = '{data: data_q, perr: perr_q, ferr: ~rx_p1};
    assign pop        = rx_valid_o && rx_ready_i;
    assign ovr_set    = push && fifo_full && !pop;

    uart_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .level_o (level_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Sticky error flags; a set in the same cycle as a clear takes priority
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            overrun_o <= 1'b0;
            break_o   <= 1'b0;
        end else begin
            if (ovr_set)        overrun_o <= 1'b1;
            else if (err_clr_i) overrun_o <= 1'b0;
            if (brk_set)        break_o   <= 1'b1;
            else if (err_clr_i) break_o   <= 1'b0;
        end
    end

    assign rx_valid_o = !fifo_empty;
    assign rx_data_o  = rx_valid_o ? head.data : 8'h00;
    assign rx_perr_o  = rx_valid_o && head.perr;
    assign rx_ferr_o  = rx_valid_o && head.ferr;
    assign busy_o     = (state != ST_IDLE);

endmodule
